// File: rtl/snn_pkg.sv
// Shared definitions for the spike-rate decode path: default widths, the
// decoder state type and a width-generic saturating increment.
package snn_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int WIN_W_DEF = 6;

  typedef enum logic {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  // Increments v, holding at the all-ones value of a w-bit field.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
    logic [31:0] max_v;
    max_v = (32'd1 << w) - 32'd1;
    return (v >= max_v) ? max_v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/spike_rate_decoder_sat_counter.sv
// CNT_W-bit spike counter: synchronous clear has priority over the
// saturating increment.
module sat_counter
  import snn_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = {CNT_W{1'b0}};
    end else if (inc) begin
      count_d = CNT_W'(sat_inc(32'(count_q), CNT_W));
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/spike_rate_decoder.sv
// Counts spikes over back-to-back windows of window_len cycles and offers
// each count on a registered valid/ready output; undeliverable counts are dropped.
module spike_rate_decoder
  import snn_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int WIN_W = WIN_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             spike_in,
  input  logic [WIN_W-1:0] window_len,
  output logic [CNT_W-1:0] rate_out,
  output logic             rate_valid,
  input  logic             rate_ready,
  output logic             overrun,
  input  logic             overrun_clr
);

  state_t           state_q, state_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [WIN_W-1:0] win_len_s;
  logic [CNT_W-1:0] spk_cnt_s;
  logic [CNT_W-1:0] result_s;
  logic [CNT_W-1:0] rate_out_q, rate_out_d;
  logic             rate_valid_q, rate_valid_d;
  logic             overrun_q, overrun_d;
  logic             spk_clr_s, spk_inc_s, last_s, xfer_s, drop_s;

  assign win_len_s = (window_len == {WIN_W{1'b0}}) ? WIN_W'(1'b1) : window_len;
  // The closing edge's own spike is folded into the delivered result.
  assign result_s  = spike_in ? CNT_W'(sat_inc(32'(spk_cnt_s), CNT_W)) : spk_cnt_s;
  assign xfer_s    = rate_valid_q & rate_ready;

  sat_counter #(.CNT_W(CNT_W)) u_spk_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clr   (spk_clr_s),
    .inc   (spk_inc_s),
    .count (spk_cnt_s)
  );

  // Window sequencing: entry, per-cycle countdown, reload on the last cycle, abort on disable.
  always_comb begin
    state_d   = state_q;
    win_cnt_d = win_cnt_q;
    spk_clr_s = 1'b0;
    spk_inc_s = 1'b0;
    last_s    = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d   = COUNT;
          win_cnt_d = win_len_s;
          spk_clr_s = 1'b1;
        end else begin
          state_d   = IDLE;
        end
      end
      COUNT: begin
        if (!enable) begin
          state_d   = IDLE;
          win_cnt_d = {WIN_W{1'b0}};
          spk_clr_s = 1'b1;
        end else if (win_cnt_q == WIN_W'(1'b1)) begin
          last_s    = 1'b1;
          win_cnt_d = win_len_s;
          spk_clr_s = 1'b1;
        end else begin
          win_cnt_d = win_cnt_q - WIN_W'(1'b1);
          spk_inc_s = spike_in;
        end
      end
      default: begin
        state_d   = IDLE;
        win_cnt_d = {WIN_W{1'b0}};
        spk_clr_s = 1'b1;
      end
    endcase
  end

  // Output slot: a new result lands if the slot is empty or drains on the same edge.
  always_comb begin
    rate_out_d   = rate_out_q;
    rate_valid_d = rate_valid_q & ~xfer_s;
    drop_s       = 1'b0;
    if (last_s) begin
      if (!rate_valid_q || xfer_s) begin
        rate_out_d   = result_s;
        rate_valid_d = 1'b1;
      end else begin
        drop_s       = 1'b1;
      end
    end else begin
      drop_s       = 1'b0;
    end
    overrun_d = drop_s ? 1'b1 : (overrun_clr ? 1'b0 : overrun_q);
  end

  // State, window counter and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      win_cnt_q    <= {WIN_W{1'b0}};
      rate_out_q   <= {CNT_W{1'b0}};
      rate_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_cnt_q    <= win_cnt_d;
      rate_out_q   <= rate_out_d;
      rate_valid_q <= rate_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rate_out   = rate_out_q;
  assign rate_valid = rate_valid_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: directed scenarios plus a randomized run, all
// checked against a window-level reference model (8-bit and 4-bit count instances).
module tb_spike_rate_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0, spk = 1'b0, rdy = 1'b0, oclr = 1'b0;
  logic [5:0] wl = 6'd0;
  logic [7:0] ro8;
  logic [3:0] ro4;
  logic       rv8, rv4, ov8, ov4;

  int nchk = 0;
  int nbad = 0;

  // Reference model: remaining cycles and raw spike total of the open window.
  bit m_run, m_valid, m_ovr;
  int m_left, m_sum, m_out;

  always #5 clk = ~clk;

  spike_rate_decoder #(.CNT_W(8), .WIN_W(6)) dut8 (
    .clk(clk), .reset(rst_n), .enable(en), .spike_in(spk), .window_len(wl),
    .rate_out(ro8), .rate_valid(rv8), .rate_ready(rdy), .overrun(ov8), .overrun_clr(oclr));

  spike_rate_decoder #(.CNT_W(4), .WIN_W(6)) dut4 (
    .clk(clk), .reset(rst_n), .enable(en), .spike_in(spk), .window_len(wl),
    .rate_out(ro4), .rate_valid(rv4), .rate_ready(rdy), .overrun(ov4), .overrun_clr(oclr));

  function automatic logic [7:0] exp8();
    return (m_out > 255) ? 8'd255 : 8'(m_out);
  endfunction

  function automatic logic [3:0] exp4();
    return (m_out > 15) ? 4'd15 : 4'(m_out);
  endfunction

  task automatic model_reset();
    m_run = 0; m_valid = 0; m_ovr = 0; m_left = 0; m_sum = 0; m_out = 0;
  endtask

  // Applies one clock edge's worth of behaviour using the inputs currently driven.
  task automatic model_edge();
    bit xfer, set_ovr;
    int n;
    xfer    = m_valid && rdy;
    set_ovr = 0;
    n       = (wl == 6'd0) ? 1 : int'(wl);
    if (xfer) m_valid = 0;
    if (!m_run) begin
      if (en) begin m_run = 1; m_left = n; m_sum = 0; end
    end else if (!en) begin
      m_run = 0; m_left = 0; m_sum = 0;
    end else if (m_left == 1) begin
      if (!m_valid) begin m_out = m_sum + int'(spk); m_valid = 1; end
      else set_ovr = 1;
      m_left = n; m_sum = 0;
    end else begin
      m_sum += int'(spk); m_left -= 1;
    end
    if (set_ovr) m_ovr = 1;
    else if (oclr) m_ovr = 0;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    nchk++;
    if ({rv8, ov8, ro8, rv4, ov4, ro4} !== 22'd0) begin
      nbad++;
      $display("FAIL reset: got v=%b o=%b r8=%0d v4=%b o4=%b r4=%0d want all 0", rv8, ov8, ro8, rv4, ov4, ro4);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    wl = 6'd4; en = 1'b1; spk = 1'b1; rdy = 1'b0;
    repeat (4) step();
    nchk++;
    if (rv8 !== 1'b0) begin nbad++; $display("FAIL basic_early: got v=%b want 0", rv8); end
    step();
    nchk++;
    if ({rv8, ro8, ro4} !== {1'b1, 8'd4, 4'd4}) begin
      nbad++; $display("FAIL basic_result: got v=%b r8=%0d r4=%0d want v=1 r8=4 r4=4", rv8, ro8, ro4);
    end
    rdy = 1'b1; en = 1'b0;
    step();
    nchk++;
    if (rv8 !== 1'b0) begin nbad++; $display("FAIL basic_drain: got v=%b want 0", rv8); end
  endtask

  task automatic test_saturation();
    wl = 6'd63; en = 1'b1; spk = 1'b1; rdy = 1'b0;
    repeat (64) step();
    nchk++;
    if ({rv8, ro8, rv4, ro4} !== {1'b1, 8'd63, 1'b1, 4'd15}) begin
      nbad++; $display("FAIL saturation: got v=%b r8=%0d v4=%b r4=%0d want v=1 r8=63 v4=1 r4=15", rv8, ro8, rv4, ro4);
    end
    en = 1'b0; rdy = 1'b1;
    step();
  endtask

  task automatic test_overrun();
    wl = 6'd2; en = 1'b1; spk = 1'b1; rdy = 1'b0;
    repeat (3) step();
    nchk++;
    if ({rv8, ov8, ro8} !== {1'b1, 1'b0, 8'd2}) begin
      nbad++; $display("FAIL overrun_first: got v=%b o=%b r=%0d want v=1 o=0 r=2", rv8, ov8, ro8);
    end
    repeat (2) step();
    nchk++;
    if ({rv8, ov8, ro8} !== {1'b1, 1'b1, 8'd2}) begin
      nbad++; $display("FAIL overrun_drop: got v=%b o=%b r=%0d want v=1 o=1 r=2", rv8, ov8, ro8);
    end
    en = 1'b0; oclr = 1'b1; rdy = 1'b1;
    step();
    oclr = 1'b0;
    nchk++;
    if ({rv8, ov8} !== 2'b00) begin
      nbad++; $display("FAIL overrun_clr: got v=%b o=%b want v=0 o=0", rv8, ov8);
    end
  endtask

  task automatic test_back_to_back();
    wl = 6'd1; en = 1'b1; rdy = 1'b1; spk = 1'b0;
    step();
    for (int k = 0; k < 6; k++) begin
      spk = (k % 2 == 0) ? 1'b1 : 1'b0;
      step();
      nchk++;
      if ({rv8, ov8, ro8} !== {1'b1, 1'b0, 7'd0, spk}) begin
        nbad++; $display("FAIL b2b[%0d]: got v=%b o=%b r=%0d want v=1 o=0 r=%0d", k, rv8, ov8, ro8, spk);
      end
    end
    en = 1'b0;
    step();
  endtask

  task automatic test_enable_drop();
    wl = 6'd2; en = 1'b1; spk = 1'b1; rdy = 1'b0;
    repeat (3) step();
    en = 1'b0;
    step();
    wl = 6'd8; en = 1'b1;
    repeat (4) step();
    en = 1'b0;
    step();
    nchk++;
    if ({rv8, ov8, ro8} !== {1'b1, 1'b0, 8'd2}) begin
      nbad++; $display("FAIL en_drop_hold: got v=%b o=%b r=%0d want v=1 o=0 r=2", rv8, ov8, ro8);
    end
    en = 1'b1; rdy = 1'b1;
    for (int k = 0; k < 9; k++) begin
      spk = (k < 6) ? 1'b1 : 1'b0;
      step();
    end
    nchk++;
    if ({rv8, ro8} !== {1'b1, 8'd5}) begin
      nbad++; $display("FAIL en_drop_fresh: got v=%b r=%0d want v=1 r=5", rv8, ro8);
    end
    en = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    wl = 6'd1; en = 1'b1; spk = 1'b1; rdy = 1'b0;
    repeat (2) step();
    nchk++;
    if ({rv8, ro8} !== {1'b1, 8'd1}) begin
      nbad++; $display("FAIL areset_setup: got v=%b r=%0d want v=1 r=1", rv8, ro8);
    end
    #2 rst_n = 1'b0;
    #1;
    nchk++;
    if ({rv8, ov8, ro8, rv4, ov4, ro4} !== 22'd0) begin
      nbad++; $display("FAIL areset_mid: got v=%b o=%b r8=%0d v4=%b o4=%b r4=%0d want all 0", rv8, ov8, ro8, rv4, ov4, ro4);
    end
    model_reset();
    en = 1'b0; spk = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      en   = ($urandom_range(0, 15) != 0);
      spk  = $urandom_range(0, 1);
      rdy  = ($urandom_range(0, 3) != 0);
      oclr = ($urandom_range(0, 7) == 0);
      wl   = ($urandom_range(0, 31) == 0) ? 6'd63 : 6'($urandom_range(0, 5));
      step();
      nchk++;
      if ({rv8, ov8, ro8, rv4, ov4, ro4} !== {m_valid, m_ovr, exp8(), m_valid, m_ovr, exp4()}) begin
        nbad++;
        $display("FAIL random[%0d]: got v=%b o=%b r8=%0d v4=%b o4=%b r4=%0d want v=%b o=%b r8=%0d r4=%0d",
                 c, rv8, ov8, ro8, rv4, ov4, ro4, m_valid, m_ovr, exp8(), exp4());
      end
    end
    oclr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_overrun();
    test_back_to_back();
    test_enable_drop();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end

endmodule
